mod_tcounter: RTL and testbench
===============================

MOD_TCOUNTER -- requirements
Module: mod_tcounter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter N, default 50: timeout length in clock cycles; legal range N >= 1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port clear, input, 1 bit: synchronous hold/restart. 1 holds the timer at zero; 0 lets it run.
REQ-006 Port done, output, 1 bit: timeout flag. It is 1 once N consecutive edges have been sampled with clear=0.

Function
REQ-007 The block SHALL contain an internal cycle counter of width $clog2(N+1) bits, so that it can hold the value N.
- It is unsigned.
- It never wraps.
REQ-008 At a rising edge with clear=1, the counter SHALL load 0 and done SHALL load 0.
- This applies regardless of the counter's current value or done's current state.
REQ-009 At a rising edge with clear=0 and counter < N, the counter SHALL increment by 1.
REQ-010 At a rising edge with clear=0 and counter = N, the counter SHALL hold at N (saturate).
- done SHALL remain 1.
REQ-011 done SHALL be a registered output, glitch-free. It is set on the same edge at which the counter becomes N.
- done = 1 SHALL appear exactly N rising edges after the first edge that samples clear=0, following a cleared state.
REQ-012 done SHALL stay 1 for as long as clear remains 0, for any duration.
REQ-013 With clear=1 sampled while done=1, done SHALL fall to 0 at that edge.
- The count SHALL restart from 0.
REQ-014 A single cycle of clear=1 at any point in the count SHALL fully restart the timeout.
- There is no partial credit for cycles already counted.
REQ-015 With N=1, done SHALL assert at the first edge that samples clear=0.
REQ-016 The block SHALL have no other state besides the counter and the done register.
REQ-017 The counter SHALL NOT be visible at the ports.

Reset
REQ-018 With rst_n=0, the counter and done SHALL go to 0 immediately, independent of clk.
REQ-019 Reset SHALL have priority over clear and over counting.
REQ-020 Reset asserted mid-count SHALL abort the count.
REQ-021 After rst_n deasserts, the first rising edge SHALL be treated like any other edge:
- if clear=0, counting starts at that edge (counter goes to 1);
- if clear=1, the counter stays at 0.
REQ-022 done SHALL be 0 in the first cycle after reset release. The exception is N=1 with clear=0 at the first edge, where done rises at that edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- N=4: hold clear=1 for 3 cycles, then drop clear -> done=0 after edges 1-3 and done=1 after edge 4; done stays 1 for 20 further cycles.
- N=4: done=1 with clear=0, then pulse clear=1 for one cycle -> done=0 after that edge; with clear low again, done=1 exactly 4 edges later.
- N=4: drop clear, raise clear after 2 edges, drop it again -> done stays 0 until 4 full edges after the second drop.
- N=4: drop clear, assert rst_n=0 asynchronously mid-cycle after 3 edges -> done=0 immediately; after release with clear=0, done=1 exactly 4 edges later.
- N=1: drop clear -> done=1 after the first edge; clear=1 -> done=0 after the next edge.
- Default N=50: drop clear -> done=0 through edge 49 and done=1 at edge 50; no wrap after 100 more edges.

Source files
------------

// File: rtl/mod_tcounter.sv
// Timeout counter: done rises once N consecutive rising edges have sampled
// clear=0, then stays high until clear or reset restarts the timeout.
module mod_tcounter #(
  parameter int N = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_p0;

  // Increment that parks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_nxt = clear ? '0 : sat_inc(cnt_p0);
  end

  // Stage p0: done is registered from the next count so it rises on the
  // same edge at which the counter reaches N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= '0;
      done_p0 <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nxt;
      done_p0 <= (cnt_nxt == CNT_MAX);
    end
  end

  assign done = done_p0;

endmodule

// File: tb/tb_mod_tcounter.sv
// Directed bench for mod_tcounter with N=4, N=1 and default N=50 instances;
// expected done values are queued per edge and compared after the edge.
module tb_mod_tcounter;

  logic clk;
  logic rst_n;
  logic clr4, clr1, clr50;
  logic done4, done1, done50;

  int n_pass;
  int n_total;

  // Behavioural model: number of consecutive edges that sampled clear=0.
  int run4, run1, run50;

  typedef struct {
    int    idx;
    logic  exp;
    string tag;
  } exp_t;

  exp_t sb[$];

  mod_tcounter #(.N(4)) u_n4 (.clk(clk), .rst_n(rst_n), .clear(clr4),  .done(done4));
  mod_tcounter #(.N(1)) u_n1 (.clk(clk), .rst_n(rst_n), .clear(clr1),  .done(done1));
  mod_tcounter          u_n50 (.clk(clk), .rst_n(rst_n), .clear(clr50), .done(done50));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  function automatic logic get_done(input int idx);
    case (idx)
      0:       return done4;
      1:       return done1;
      default: return done50;
    endcase
  endfunction

  task automatic push_expected(input string tag);
    sb.push_back('{0, (run4  >= 4),  {tag, "/n4"}});
    sb.push_back('{1, (run1  >= 1),  {tag, "/n1"}});
    sb.push_back('{2, (run50 >= 50), {tag, "/n50"}});
  endtask

  task automatic check_all();
    exp_t e;
    logic obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = get_done(e.idx);
      n_total++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: done=%0b expected %0b", e.tag, obs, e.exp);
    end
  endtask

  // Drive clears, predict the post-edge done values, take one edge, compare.
  task automatic step(input logic c4, input logic c1, input logic c50, input string tag);
    clr4  = c4;
    clr1  = c1;
    clr50 = c50;
    run4  = c4  ? 0 : run4  + 1;
    run1  = c1  ? 0 : run1  + 1;
    run50 = c50 ? 0 : run50 + 1;
    push_expected(tag);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    run4    = 0;
    run1    = 0;
    run50   = 0;
    rst_n   = 1'b0;
    clr4    = 1'b1;
    clr1    = 1'b1;
    clr50   = 1'b1;

    #2;
    push_expected("reset_state");
    check_all();
    rst_n = 1'b1;

    // N=4: clear held for 3 edges, then released; done stays high for 20 more.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, "s1_hold");
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b1, "s1_run");

    // N=4: one-cycle clear pulse while done=1 restarts the full timeout.
    step(1'b1, 1'b1, 1'b1, "s2_pulse");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "s2_rerun");

    // N=4: clear after 2 counted edges gives no partial credit.
    step(1'b1, 1'b1, 1'b1, "s3_init");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, "s3_part");
    step(1'b1, 1'b1, 1'b1, "s3_clear");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "s3_full");

    // Async reset mid-count; N=1 is already done so the drop is observable.
    step(1'b1, 1'b1, 1'b1, "s4_init");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "s4_count");
    #2;
    rst_n = 1'b0;
    run4  = 0;
    run1  = 0;
    run50 = 0;
    #1;
    push_expected("s4_async_rst");
    check_all();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, "s4_post_rst");

    // N=1: done on the first clear=0 edge, cleared on the next clear=1 edge.
    step(1'b1, 1'b1, 1'b1, "s5_init");
    step(1'b1, 1'b0, 1'b1, "s5_n1_set");
    step(1'b1, 1'b1, 1'b1, "s5_n1_clr");
    step(1'b1, 1'b0, 1'b1, "s5_n1_again");

    // Default N=50: done at edge 50, then no wrap over 100 further edges.
    step(1'b1, 1'b1, 1'b1, "s6_init");
    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 1'b0, "s6_n50");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
